// File: rtl/sdc_dat_bidir_ctrl.sv
// SD DAT bus direction controller: owns the tri-state DATA pins, grants TX/RX
// direction with a counted bus-released turnaround on every change.
module sdc_dat_bidir_ctrl #(
  parameter int                WIDTH       = 4,
  parameter int                TURN_CYCLES = 2,
  parameter logic [WIDTH-1:0]  IDLE_LEVEL  = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             DIR_REQ,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             DIR_ACK,
  output logic             BUSY,
  output logic             OE,
  inout  wire  [WIDTH-1:0] DATA
);

  localparam int                CNT_W    = $clog2(TURN_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TURN_CYCLES - 1);

  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_TURN_TX = 2'd1;
  localparam logic [1:0] ST_TX      = 2'd2;
  localparam logic [1:0] ST_TURN_RX = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg;
  logic             oe_reg, dir_ack_reg, busy_reg;
  logic             tx_accept;

  assign TX_READY  = (state_reg == ST_TX) && DIR_REQ;
  assign tx_accept = TX_READY && TX_VALID;

  // DIR_REQ is only looked at in RX and TX; turnarounds always run to completion.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RX: begin
        if (DIR_REQ) begin
          state_next = ST_TURN_TX;
          cnt_next   = CNT_LOAD;
        end
      end
      ST_TURN_TX: begin
        if (cnt_reg == '0) state_next = ST_TX;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_TX: begin
        if (!DIR_REQ) begin
          state_next = ST_TURN_RX;
          cnt_next   = CNT_LOAD;
        end
      end
      ST_TURN_RX: begin
        if (cnt_reg == '0) state_next = ST_RX;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = ST_RX;
    endcase
  end

  always_comb begin
    out_next = out_reg;
    if (state_reg != ST_TX && state_next == ST_TX) out_next = IDLE_LEVEL;
    else if (tx_accept)                             out_next = TX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg    <= ST_RX;
      cnt_reg      <= '0;
      out_reg      <= IDLE_LEVEL;
      oe_reg       <= 1'b0;
      dir_ack_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      out_reg      <= out_next;
      // Output flags follow the next state so OE drops on the same edge TX is left.
      oe_reg       <= (state_next == ST_TX);
      dir_ack_reg  <= (state_next == ST_TX);
      busy_reg     <= (state_next == ST_TURN_TX) || (state_next == ST_TURN_RX);
      rx_data_reg  <= DATA;
      rx_valid_reg <= (state_reg == ST_RX);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pad
      assign DATA[gi] = oe_reg ? out_reg[gi] : 1'bz;
    end
  endgenerate

  assign OE       = oe_reg;
  assign DIR_ACK  = dir_ack_reg;
  assign BUSY     = busy_reg;
  assign RX_DATA  = rx_data_reg;
  assign RX_VALID = rx_valid_reg;

endmodule

// File: tb/tb_sdc_dat_bidir_ctrl.sv
// Directed bench for sdc_dat_bidir_ctrl (WIDTH=4, TURN_CYCLES=2) with a
// card-side tri-state driver on DATA.
module tb_sdc_dat_bidir_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dir_req;
  logic [3:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] rx_data;
  logic       rx_valid;
  logic       dir_ack;
  logic       busy;
  logic       oe;
  wire  [3:0] dat_bus;
  logic       card_oe;
  logic [3:0] card_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dat_bus = card_oe ? card_val : 4'bzzzz;

  sdc_dat_bidir_ctrl #(
    .WIDTH       (4),
    .TURN_CYCLES (2),
    .IDLE_LEVEL  (4'hF)
  ) dut (
    .CLK      (clk),
    .RESET_N  (reset_n),
    .DIR_REQ  (dir_req),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .DIR_ACK  (dir_ack),
    .BUSY     (busy),
    .OE       (oe),
    .DATA     (dat_bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bus contention: DUT driving while the card drives.
  always @(negedge clk) begin
    if (oe && card_oe) begin
      checks++;
      errors++;
      $display("FAIL contention: oe=%0b card_oe=%0b", oe, card_oe);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    dir_req  = 1'b1;
    tx_data  = 4'h0;
    tx_valid = 1'b0;
    card_oe  = 1'b0;
    card_val = 4'h0;

    // Reset held 3 cycles with DIR_REQ high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_oe", {7'd0, oe}, 8'd0);
      chk("rst_rxvalid", {7'd0, rx_valid}, 8'd0);
      chk("rst_txready", {7'd0, tx_ready}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_diracks", {7'd0, dir_ack}, 8'd0);
      chk("rst_rxdata", {4'd0, rx_data}, 8'd0);
    end
    reset_n = 1'b1;
    tick();
    chk("rel1_busy", {7'd0, busy}, 8'd1);
    chk("rel1_oe", {7'd0, oe}, 8'd0);
    chk("rel1_rxvalid", {7'd0, rx_valid}, 8'd1);
    tick();
    chk("rel2_busy", {7'd0, busy}, 8'd1);
    chk("rel2_oe", {7'd0, oe}, 8'd0);
    chk("rel2_rxvalid", {7'd0, rx_valid}, 8'd0);
    tick();
    chk("rel3_oe", {7'd0, oe}, 8'd1);
    chk("rel3_ack", {7'd0, dir_ack}, 8'd1);
    chk("rel3_busy", {7'd0, busy}, 8'd0);
    chk("rel3_data", {4'd0, dat_bus}, 8'h0F);
    chk("rel3_ready", {7'd0, tx_ready}, 8'd1);

    // Writes, then hold under TX_VALID=0
    tx_valid = 1'b1;
    tx_data  = 4'hA;
    tick();
    chk("wr_a", {4'd0, dat_bus}, 8'h0A);
    tx_data = 4'h5;
    tick();
    chk("wr_5", {4'd0, dat_bus}, 8'h05);
    tx_data = 4'h3;
    tick();
    chk("wr_3", {4'd0, dat_bus}, 8'h03);
    tx_valid = 1'b0;
    tx_data  = 4'h9;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_data", {4'd0, dat_bus}, 8'h03);
      chk("hold_ready", {7'd0, tx_ready}, 8'd1);
    end

    // Release to RX; offered word must not be accepted
    dir_req  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 4'hC;
    #1;
    chk("drop_ready", {7'd0, tx_ready}, 8'd0);
    tick();
    chk("trx1_oe", {7'd0, oe}, 8'd0);
    chk("trx1_busy", {7'd0, busy}, 8'd1);
    chk("trx1_ack", {7'd0, dir_ack}, 8'd0);
    chk("trx1_rxvalid", {7'd0, rx_valid}, 8'd0);
    chk("trx1_outreg", {4'd0, dut.out_reg}, 8'h03);
    tx_valid = 1'b0;
    tick();
    chk("trx2_oe", {7'd0, oe}, 8'd0);
    chk("trx2_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("rx_busy", {7'd0, busy}, 8'd0);
    chk("rx_oe", {7'd0, oe}, 8'd0);
    chk("rx_rxvalid0", {7'd0, rx_valid}, 8'd0);
    card_oe  = 1'b1;
    card_val = 4'h6;
    tick();
    chk("rd_valid", {7'd0, rx_valid}, 8'd1);
    chk("rd_6", {4'd0, rx_data}, 8'h06);
    card_val = 4'h9;
    tick();
    chk("rd_9", {4'd0, rx_data}, 8'h09);

    // Write entry from RX
    card_oe = 1'b0;
    dir_req = 1'b1;
    tick();
    chk("wtx1_busy", {7'd0, busy}, 8'd1);
    chk("wtx1_oe", {7'd0, oe}, 8'd0);
    chk("wtx1_rxvalid", {7'd0, rx_valid}, 8'd1);
    tick();
    chk("wtx2_busy", {7'd0, busy}, 8'd1);
    chk("wtx2_rxvalid", {7'd0, rx_valid}, 8'd0);
    tick();
    chk("wtx3_oe", {7'd0, oe}, 8'd1);
    chk("wtx3_idle", {4'd0, dat_bus}, 8'h0F);
    chk("wtx3_busy", {7'd0, busy}, 8'd0);
    tx_valid = 1'b1;
    tx_data  = 4'hA;
    tick();
    chk("wtx_a", {4'd0, dat_bus}, 8'h0A);
    tx_data = 4'h5;
    tick();
    chk("wtx_5", {4'd0, dat_bus}, 8'h05);
    tx_valid = 1'b0;

    // Back to RX, then reverse request during TURN_TO_TX
    dir_req = 1'b0;
    tick();
    tick();
    tick();
    chk("rev_rx_oe", {7'd0, oe}, 8'd0);
    dir_req = 1'b1;
    tick();
    chk("rev1_busy", {7'd0, busy}, 8'd1);
    dir_req = 1'b0;
    tick();
    chk("rev2_busy", {7'd0, busy}, 8'd1);
    chk("rev2_oe", {7'd0, oe}, 8'd0);
    tick();
    chk("rev3_oe", {7'd0, oe}, 8'd1);
    chk("rev3_ack", {7'd0, dir_ack}, 8'd1);
    chk("rev3_idle", {4'd0, dat_bus}, 8'h0F);
    chk("rev3_ready", {7'd0, tx_ready}, 8'd0);
    tick();
    chk("rev4_oe", {7'd0, oe}, 8'd0);
    chk("rev4_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("rev5_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("rev6_busy", {7'd0, busy}, 8'd0);
    chk("rev6_oe", {7'd0, oe}, 8'd0);
    card_oe  = 1'b1;
    card_val = 4'h7;
    tick();
    chk("rev_rd7", {4'd0, rx_data}, 8'h07);
    chk("rev_rdvalid", {7'd0, rx_valid}, 8'd1);
    card_oe = 1'b0;

    // Mid-burst reset
    dir_req = 1'b1;
    tick();
    tick();
    tick();
    chk("mr_oe", {7'd0, oe}, 8'd1);
    tx_valid = 1'b1;
    tx_data  = 4'h2;
    tick();
    chk("mr_2", {4'd0, dat_bus}, 8'h02);
    tx_data = 4'h8;
    reset_n = 1'b0;
    tick();
    chk("mr_oe0", {7'd0, oe}, 8'd0);
    chk("mr_ack0", {7'd0, dir_ack}, 8'd0);
    chk("mr_busy0", {7'd0, busy}, 8'd0);
    chk("mr_rxvalid", {7'd0, rx_valid}, 8'd0);
    chk("mr_rxdata", {4'd0, rx_data}, 8'h00);
    chk("mr_ready", {7'd0, tx_ready}, 8'd0);
    chk("mr_outreg", {4'd0, dut.out_reg}, 8'h0F);
    tx_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    chk("mr_rel_busy", {7'd0, busy}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
